// File: rtl/snax_gemm_shell_controller.sv
// GEMM accelerator shell: queued CSR configurations, a core-output-to-stream serializer and status counters.
// Optional: define SNAX_GEMM_SHELL_STALL_CNT_EN to add the streamer stall counter in status word 3.
module snax_gemm_shell_controller #(
  parameter int RegRWCount     = 5,
  parameter int RegROCount     = 4,
  parameter int RegDataWidth   = 32,
  parameter int CfgDepth       = 2,
  parameter int CoreOutWidth   = 2048,
  parameter int StreamOutWidth = 512
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [RegDataWidth-1:0]   csr_reg_set_i [RegRWCount],
  input  logic                      csr_reg_set_valid_i,
  output logic                      csr_reg_set_ready_o,
  output logic [RegDataWidth-1:0]   csr_reg_ro_set_o [RegROCount],
  output logic [RegDataWidth-1:0]   core_cfg_o [RegRWCount],
  output logic                      core_cfg_valid_o,
  input  logic                      core_cfg_ready_i,
  input  logic                      core_busy_i,
  input  logic [CoreOutWidth-1:0]   core_d_i,
  input  logic                      core_d_valid_i,
  output logic                      core_d_ready_o,
  output logic [StreamOutWidth-1:0] acc2stream_0_data_o,
  output logic                      acc2stream_0_valid_o,
  input  logic                      acc2stream_0_ready_i
);

  localparam int Beats = CoreOutWidth / StreamOutWidth;
  localparam int PtrW  = (CfgDepth > 1) ? $clog2(CfgDepth) : 1;
  localparam int CntW  = $clog2(CfgDepth + 1);
  localparam int BeatW = (Beats > 1) ? $clog2(Beats) : 1;

  logic [RegDataWidth-1:0] cfg_mem [CfgDepth][RegRWCount];
  logic [PtrW-1:0]         wr_ptr;
  logic [PtrW-1:0]         rd_ptr;
  logic [CntW-1:0]         cfg_count;
  logic                    cfg_full;
  logic                    cfg_empty;
  logic                    cfg_push;
  logic                    cfg_pop;

  // Pointers wrap explicitly so the depth need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(CfgDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign cfg_full            = (cfg_count == CntW'(CfgDepth));
  assign cfg_empty           = (cfg_count == '0);
  assign csr_reg_set_ready_o = !cfg_full;
  assign core_cfg_valid_o    = !cfg_empty;
  assign cfg_push            = csr_reg_set_valid_i && !cfg_full;
  assign cfg_pop             = core_cfg_valid_o && core_cfg_ready_i;

  always_comb begin
    for (int r = 0; r < RegRWCount; r++) begin
      core_cfg_o[r] = cfg_mem[rd_ptr][r];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cfg_count <= '0;
      for (int d = 0; d < CfgDepth; d++) begin
        for (int r = 0; r < RegRWCount; r++) begin
          cfg_mem[d][r] <= '0;
        end
      end
    end else begin
      if (cfg_push) begin
        for (int r = 0; r < RegRWCount; r++) begin
          cfg_mem[wr_ptr][r] <= csr_reg_set_i[r];
        end
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (cfg_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({cfg_push, cfg_pop})
        2'b10:   cfg_count <= cfg_count + 1'b1;
        2'b01:   cfg_count <= cfg_count - 1'b1;
        default: cfg_count <= cfg_count;
      endcase
    end
  end

  typedef enum logic {
    IDLE,
    SEND
  } ser_state_e;

  ser_state_e              state_q;
  ser_state_e              state_d;
  logic [CoreOutWidth-1:0] buf_q;
  logic [CoreOutWidth-1:0] buf_d;
  logic [BeatW-1:0]        beat_cnt_q;
  logic [BeatW-1:0]        beat_cnt_d;
  logic                    last_beat;
  logic                    beat_hs;
  logic                    word_done;

  assign last_beat = (beat_cnt_q == BeatW'(Beats - 1));
  assign beat_hs   = (state_q == SEND) && acc2stream_0_ready_i;
  assign word_done = beat_hs && last_beat;

  // A new word may be taken on the same edge the last beat leaves, so back-to-back words stream without a bubble.
  always_comb begin
    state_d              = state_q;
    buf_d                = buf_q;
    beat_cnt_d           = beat_cnt_q;
    core_d_ready_o       = 1'b0;
    acc2stream_0_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        core_d_ready_o = 1'b1;
        if (core_d_valid_i) begin
          buf_d      = core_d_i;
          beat_cnt_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        acc2stream_0_valid_o = 1'b1;
        if (word_done) begin
          core_d_ready_o = 1'b1;
          if (core_d_valid_i) begin
            buf_d      = core_d_i;
            beat_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (beat_hs) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc2stream_0_data_o = '0;
    if (state_q == SEND) begin
      acc2stream_0_data_o = buf_q[int'(beat_cnt_q) * StreamOutWidth +: StreamOutWidth];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  logic                    busy;
  logic                    clear_cnt;
  logic [RegDataWidth-1:0] cycle_cnt;
  logic [RegDataWidth-1:0] word_cnt;
  logic [RegDataWidth-1:0] stall_cnt;

  // A configuration arriving while nothing is in flight marks the start of a new job.
  assign busy      = core_busy_i || core_cfg_valid_o || (state_q == SEND);
  assign clear_cnt = cfg_push && !busy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_cnt <= '0;
      word_cnt  <= '0;
    end else if (clear_cnt) begin
      cycle_cnt <= '0;
      word_cnt  <= '0;
    end else begin
      if (busy && (cycle_cnt != '1)) begin
        cycle_cnt <= cycle_cnt + 1'b1;
      end
      if (word_done) begin
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

`ifdef SNAX_GEMM_SHELL_STALL_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt <= '0;
    end else if (clear_cnt) begin
      stall_cnt <= '0;
    end else if (acc2stream_0_valid_o && !acc2stream_0_ready_i && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

  always_comb begin
    for (int i = 0; i < RegROCount; i++) begin
      csr_reg_ro_set_o[i] = '0;
    end
    csr_reg_ro_set_o[0] = {{(RegDataWidth - 1){1'b0}}, busy};
    csr_reg_ro_set_o[1] = cycle_cnt;
    csr_reg_ro_set_o[2] = word_cnt;
    csr_reg_ro_set_o[3] = stall_cnt;
  end

endmodule

// File: tb/tb_snax_gemm_shell_controller.sv
// Self-checking bench for snax_gemm_shell_controller: scoreboard queues hold expected configs and stream beats.
module tb_snax_gemm_shell_controller;

  localparam int RW    = 5;
  localparam int RO    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int COW   = 2048;
  localparam int SOW   = 512;
  localparam int BEATS = COW / SOW;
  localparam int CFGW  = RW * DW;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic [DW-1:0]  csr_set [RW];
  logic           csr_valid;
  logic           csr_ready;
  logic [DW-1:0]  ro_set [RO];
  logic [DW-1:0]  core_cfg [RW];
  logic           core_cfg_valid;
  logic           core_cfg_ready;
  logic           core_busy;
  logic [COW-1:0] core_d;
  logic           core_d_valid;
  logic           core_d_ready;
  logic [SOW-1:0] s_data;
  logic           s_valid;
  logic           s_ready;

  int total_cnt = 0;
  int pass_cnt = 0;
  logic [SOW-1:0]  beat_q[$];
  logic [CFGW-1:0] cfg_q[$];

  snax_gemm_shell_controller #(
    .RegRWCount(RW), .RegROCount(RO), .RegDataWidth(DW),
    .CfgDepth(DEPTH), .CoreOutWidth(COW), .StreamOutWidth(SOW)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .csr_reg_set_i(csr_set),
    .csr_reg_set_valid_i(csr_valid),
    .csr_reg_set_ready_o(csr_ready),
    .csr_reg_ro_set_o(ro_set),
    .core_cfg_o(core_cfg),
    .core_cfg_valid_o(core_cfg_valid),
    .core_cfg_ready_i(core_cfg_ready),
    .core_busy_i(core_busy),
    .core_d_i(core_d),
    .core_d_valid_i(core_d_valid),
    .core_d_ready_o(core_d_ready),
    .acc2stream_0_data_o(s_data),
    .acc2stream_0_valid_o(s_valid),
    .acc2stream_0_ready_i(s_ready)
  );

  always #5 clk_i = ~clk_i;

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_cfg(input logic [CFGW-1:0] v);
    for (int r = 0; r < RW; r++) csr_set[r] = v[r*DW +: DW];
  endtask

  function automatic logic [CFGW-1:0] pack_cfg();
    logic [CFGW-1:0] p;
    for (int r = 0; r < RW; r++) p[r*DW +: DW] = core_cfg[r];
    return p;
  endfunction

  function automatic logic [COW-1:0] rand_word();
    logic [COW-1:0] w;
    for (int j = 0; j < COW / 32; j++) w[j*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [CFGW-1:0] rand_cfg();
    logic [CFGW-1:0] c;
    for (int r = 0; r < RW; r++) c[r*DW +: DW] = $urandom;
    return c;
  endfunction

  task automatic idle_inputs();
    csr_valid = 1'b0;
    drive_cfg('0);
    core_cfg_ready = 1'b0;
    core_busy = 1'b0;
    core_d = '0;
    core_d_valid = 1'b0;
    s_ready = 1'b1;
  endtask

  task automatic test_reset();
    logic ok;
    rst_ni = 1'b0;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      csr_valid = 1'($urandom_range(0, 1));
      drive_cfg(rand_cfg());
      core_cfg_ready = 1'($urandom_range(0, 1));
      core_d = rand_word();
      core_d_valid = 1'($urandom_range(0, 1));
      s_ready = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      total_cnt++;
      if (csr_ready !== 1'b1 || core_cfg_valid !== 1'b0 || core_d_ready !== 1'b1 ||
          s_valid !== 1'b0 || s_data !== '0)
        $display("[TB] FAIL reset_outputs: got rdy=%b cfgv=%b drdy=%b sv=%b want 1 0 1 0",
                 csr_ready, core_cfg_valid, core_d_ready, s_valid);
      else pass_cnt++;
      ok = 1'b1;
      for (int i = 0; i < RO; i++) if (ro_set[i] !== '0) ok = 1'b0;
      total_cnt++;
      if (!ok) $display("[TB] FAIL reset_ro: got %h %h %h %h want all 0",
                        ro_set[0], ro_set[1], ro_set[2], ro_set[3]);
      else pass_cnt++;
    end
    next_cycle();
    idle_inputs();
    rst_ni = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      total_cnt++;
      if (csr_ready !== 1'b1 || core_cfg_valid !== 1'b0 || core_d_ready !== 1'b1 ||
          s_valid !== 1'b0 || ro_set[0] !== '0 || ro_set[1] !== '0)
        $display("[TB] FAIL post_reset_idle: got rdy=%b cfgv=%b drdy=%b sv=%b ro0=%h ro1=%h want 1 0 1 0 0 0",
                 csr_ready, core_cfg_valid, core_d_ready, s_valid, ro_set[0], ro_set[1]);
      else pass_cnt++;
      next_cycle();
    end
  endtask

  task automatic test_fifo_fill();
    logic [CFGW-1:0] cfgs [3];
    logic [CFGW-1:0] exp_cfg;
    for (int n = 0; n < 3; n++)
      for (int r = 0; r < RW; r++) cfgs[n][r*DW +: DW] = 32'hA000_0000 + 32'(n * 16 + r);
    core_cfg_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      next_cycle();
      csr_valid = 1'b1;
      drive_cfg(cfgs[n]);
      @(negedge clk_i);
      total_cnt++;
      if (n == 0 && (csr_ready !== 1'b1 || core_cfg_valid !== 1'b0))
        $display("[TB] FAIL fill_first_push: got rdy=%b cfgv=%b want 1 0", csr_ready, core_cfg_valid);
      else if (n == 1 && (csr_ready !== 1'b1 || core_cfg_valid !== 1'b1))
        $display("[TB] FAIL fill_second_push: got rdy=%b cfgv=%b want 1 1", csr_ready, core_cfg_valid);
      else if (n == 2 && csr_ready !== 1'b0)
        $display("[TB] FAIL fill_full_ready: got %b want 0", csr_ready);
      else pass_cnt++;
      if (csr_valid && csr_ready) cfg_q.push_back(cfgs[n]);
    end
    total_cnt++;
    if (cfg_q.size() == 0 || pack_cfg() !== cfg_q[0])
      $display("[TB] FAIL fill_head_a: got %h want %h", pack_cfg(), cfgs[0]);
    else pass_cnt++;
    for (int p = 0; p < 2; p++) begin
      next_cycle();
      csr_valid = 1'b0;
      core_cfg_ready = 1'b1;
      @(negedge clk_i);
      total_cnt++;
      if (!(core_cfg_valid && core_cfg_ready) || cfg_q.size() == 0) begin
        $display("[TB] FAIL fill_pop: got cfgv=%b queued=%0d want 1 and nonzero", core_cfg_valid, cfg_q.size());
      end else begin
        exp_cfg = cfg_q.pop_front();
        if (pack_cfg() !== exp_cfg) $display("[TB] FAIL fill_pop_data: got %h want %h", pack_cfg(), exp_cfg);
        else pass_cnt++;
      end
      next_cycle();
      core_cfg_ready = 1'b0;
      @(negedge clk_i);
      total_cnt++;
      if (p == 0 && (csr_ready !== 1'b1 || cfg_q.size() == 0 || pack_cfg() !== cfg_q[0]))
        $display("[TB] FAIL fill_after_pop: got rdy=%b head=%h want 1 %h", csr_ready, pack_cfg(), cfgs[1]);
      else if (p == 1 && core_cfg_valid !== 1'b0)
        $display("[TB] FAIL fill_third_rejected: got cfgv=%b want 0", core_cfg_valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_serialize();
    logic [COW-1:0] w;
    logic [SOW-1:0] exp_beat;
    int n_beats = 0;
    int prev = -1;
    bit gap = 1'b0;
    for (int k = 0; k < BEATS; k++) w[k*SOW +: SOW] = SOW'(k);
    s_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      next_cycle();
      core_d_valid = (cyc == 0);
      core_d = w;
      @(negedge clk_i);
      if (s_valid && s_ready) begin
        total_cnt++;
        if (beat_q.size() == 0) begin
          $display("[TB] FAIL ser_beat: got unexpected beat %h want none", s_data);
        end else begin
          exp_beat = beat_q.pop_front();
          if (s_data !== exp_beat) $display("[TB] FAIL ser_beat%0d: got %h want %h", n_beats, s_data, exp_beat);
          else pass_cnt++;
        end
        if (prev >= 0 && cyc != prev + 1) gap = 1'b1;
        prev = cyc;
        n_beats++;
      end
      if (core_d_valid && core_d_ready)
        for (int k = 0; k < BEATS; k++) beat_q.push_back(w[k*SOW +: SOW]);
    end
    total_cnt++;
    if (n_beats != BEATS || gap || beat_q.size() != 0)
      $display("[TB] FAIL ser_beat_count: got %0d beats gap=%b left=%0d want %0d 0 0", n_beats, gap, beat_q.size(), BEATS);
    else pass_cnt++;
    total_cnt++;
    if (ro_set[2] !== 32'd1) $display("[TB] FAIL ser_words: got %0d want 1", ro_set[2]);
    else pass_cnt++;
    beat_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [COW-1:0] words [2];
    logic [SOW-1:0] exp_beat;
    int sent = 0;
    int n_beats = 0;
    int first = -1;
    int last = -1;
    words[0] = rand_word();
    words[1] = rand_word();
    next_cycle();
    csr_valid = 1'b1;
    drive_cfg(rand_cfg());
    core_cfg_ready = 1'b1;
    next_cycle();
    csr_valid = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (cyc != 0) next_cycle();
      core_d_valid = (sent < 2);
      core_d = words[(sent < 2) ? sent : 1];
      @(negedge clk_i);
      if (s_valid && s_ready) begin
        total_cnt++;
        if (beat_q.size() == 0) begin
          $display("[TB] FAIL b2b_beat: got unexpected beat %h want none", s_data);
        end else begin
          exp_beat = beat_q.pop_front();
          if (s_data !== exp_beat) $display("[TB] FAIL b2b_beat%0d: got %h want %h", n_beats, s_data, exp_beat);
          else pass_cnt++;
        end
        if (first < 0) first = cyc;
        last = cyc;
        n_beats++;
      end
      if (core_d_valid && core_d_ready) begin
        for (int k = 0; k < BEATS; k++) beat_q.push_back(words[sent][k*SOW +: SOW]);
        sent++;
      end
    end
    total_cnt++;
    if (n_beats != 2 * BEATS || last - first != 2 * BEATS - 1 || beat_q.size() != 0)
      $display("[TB] FAIL b2b_no_bubble: got %0d beats span %0d left %0d want %0d %0d 0",
               n_beats, last - first, beat_q.size(), 2 * BEATS, 2 * BEATS - 1);
    else pass_cnt++;
    total_cnt++;
    if (ro_set[2] !== 32'd2) $display("[TB] FAIL b2b_words: got %0d want 2", ro_set[2]);
    else pass_cnt++;
    core_cfg_ready = 1'b0;
    beat_q.delete();
  endtask

  task automatic test_counter_clear();
    next_cycle();
    csr_valid = 1'b1;
    drive_cfg(rand_cfg());
    core_cfg_ready = 1'b0;
    @(negedge clk_i);
    total_cnt++;
    if (ro_set[1] === '0 || $isunknown(ro_set[1]))
      $display("[TB] FAIL clr_prior_cycles: got %h want nonzero", ro_set[1]);
    else pass_cnt++;
    next_cycle();
    csr_valid = 1'b0;
    @(negedge clk_i);
    total_cnt++;
    if (ro_set[1] !== '0 || ro_set[2] !== '0 || ro_set[0] !== 32'd1)
      $display("[TB] FAIL clr_cleared: got ro0=%0d ro1=%0d ro2=%0d want 1 0 0", ro_set[0], ro_set[1], ro_set[2]);
    else pass_cnt++;
    for (int c = 0; c < 3; c++) next_cycle();
    @(negedge clk_i);
    total_cnt++;
    if (ro_set[1] !== 32'd3) $display("[TB] FAIL clr_count_up: got %0d want 3", ro_set[1]);
    else pass_cnt++;
    next_cycle();
    core_cfg_ready = 1'b1;
    next_cycle();
    core_cfg_ready = 1'b0;
    @(negedge clk_i);
    total_cnt++;
    if (ro_set[0] !== '0 || ro_set[1] !== 32'd5)
      $display("[TB] FAIL clr_idle_hold: got ro0=%0d ro1=%0d want 0 5", ro_set[0], ro_set[1]);
    else pass_cnt++;
    next_cycle();
    core_busy = 1'b1;
    @(negedge clk_i);
    total_cnt++;
    if (ro_set[0] !== 32'd1 || ro_set[1] !== 32'd5)
      $display("[TB] FAIL clr_core_busy: got ro0=%0d ro1=%0d want 1 5", ro_set[0], ro_set[1]);
    else pass_cnt++;
    next_cycle();
    csr_valid = 1'b1;
    next_cycle();
    csr_valid = 1'b0;
    @(negedge clk_i);
    total_cnt++;
    if (ro_set[1] !== 32'd7) $display("[TB] FAIL clr_busy_push_no_clear: got %0d want 7", ro_set[1]);
    else pass_cnt++;
    next_cycle();
    core_busy = 1'b0;
    core_cfg_ready = 1'b1;
    next_cycle();
    core_cfg_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [COW-1:0] w;
    logic [SOW-1:0] exp_beat;
    logic [DW-1:0] exp_stall;
    int n_beats = 0;
    int stall = 0;
`ifdef SNAX_GEMM_SHELL_STALL_CNT_EN
    exp_stall = 32'd5;
`else
    exp_stall = 32'd0;
`endif
    w = rand_word();
    next_cycle();
    csr_valid = 1'b1;
    drive_cfg(rand_cfg());
    core_cfg_ready = 1'b1;
    next_cycle();
    csr_valid = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc != 0) next_cycle();
      core_d_valid = (cyc == 0);
      core_d = w;
      s_ready = !(n_beats == 2 && stall < 5);
      if (!s_ready) stall++;
      @(negedge clk_i);
      if (!s_ready) begin
        total_cnt++;
        if (!(s_valid === 1'b1 && beat_q.size() > 0 && s_data === beat_q[0]))
          $display("[TB] FAIL bp_hold: got valid=%b data=%h want held beat 2", s_valid, s_data);
        else pass_cnt++;
      end
      if (s_valid && s_ready) begin
        total_cnt++;
        if (beat_q.size() == 0) begin
          $display("[TB] FAIL bp_beat: got unexpected beat %h want none", s_data);
        end else begin
          exp_beat = beat_q.pop_front();
          if (s_data !== exp_beat) $display("[TB] FAIL bp_beat%0d: got %h want %h", n_beats, s_data, exp_beat);
          else pass_cnt++;
        end
        n_beats++;
      end
      if (core_d_valid && core_d_ready)
        for (int k = 0; k < BEATS; k++) beat_q.push_back(w[k*SOW +: SOW]);
    end
    total_cnt++;
    if (n_beats != BEATS || beat_q.size() != 0 || ro_set[2] !== 32'd1)
      $display("[TB] FAIL bp_complete: got %0d beats left %0d words %0d want %0d 0 1",
               n_beats, beat_q.size(), ro_set[2], BEATS);
    else pass_cnt++;
    total_cnt++;
    if (ro_set[3] !== exp_stall) $display("[TB] FAIL bp_stall_cnt: got %0d want %0d", ro_set[3], exp_stall);
    else pass_cnt++;
    core_cfg_ready = 1'b0;
    s_ready = 1'b1;
    beat_q.delete();
  endtask

  task automatic test_reset_midop();
    logic [COW-1:0] w;
    logic [SOW-1:0] exp_beat;
    w = rand_word();
    next_cycle();
    csr_valid = 1'b1;
    drive_cfg(rand_cfg());
    core_d_valid = 1'b1;
    core_d = w;
    @(negedge clk_i);
    if (core_d_valid && core_d_ready)
      for (int k = 0; k < BEATS; k++) beat_q.push_back(w[k*SOW +: SOW]);
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      csr_valid = 1'b0;
      core_d_valid = 1'b0;
      @(negedge clk_i);
      total_cnt++;
      if (!s_valid || beat_q.size() == 0) begin
        $display("[TB] FAIL midop_beat%0d: got valid=%b queued=%0d want 1 and nonzero", c, s_valid, beat_q.size());
      end else begin
        exp_beat = beat_q.pop_front();
        if (s_data !== exp_beat) $display("[TB] FAIL midop_beat%0d: got %h want %h", c, s_data, exp_beat);
        else pass_cnt++;
      end
    end
    rst_ni = 1'b0;
    beat_q.delete();
    #1;
    total_cnt++;
    if (s_valid !== 1'b0 || s_data !== '0 || core_cfg_valid !== 1'b0 || csr_ready !== 1'b1 || ro_set[1] !== '0)
      $display("[TB] FAIL midop_reset: got sv=%b cfgv=%b rdy=%b ro1=%0d want 0 0 1 0",
               s_valid, core_cfg_valid, csr_ready, ro_set[1]);
    else pass_cnt++;
    next_cycle();
    rst_ni = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      total_cnt++;
      if (s_valid !== 1'b0 || core_cfg_valid !== 1'b0)
        $display("[TB] FAIL midop_no_replay: got sv=%b cfgv=%b want 0 0", s_valid, core_cfg_valid);
      else pass_cnt++;
      next_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_fifo_fill();
    test_serialize();
    test_back_to_back();
    test_counter_clear();
    test_backpressure();
    test_reset_midop();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/snax_gemm_shell_controller.md
Name: snax_gemm_shell_controller

Overview:
Parametrised next-generation GEMM accelerator shell. It sits between the CSR manager, the GEMM core and the output streamer. It queues CSR configurations in a CfgDepth-deep FIFO so the core can be reprogrammed while it is busy. It splits each wide core output word into narrower streamer beats, and it exposes busy, cycle, output-word and (optionally) stall counters as read-only CSRs.

Parameters:
RegRWCount, 5, number of RW CSR words per configuration; all are forwarded to the core.
RegROCount, 4, number of RO CSR words; must be at least 4.
RegDataWidth, 32, CSR word width.
CfgDepth, 2, configuration FIFO depth; must be at least 1; need not be a power of two.
CoreOutWidth, 2048, core output word width.
StreamOutWidth, 512, streamer beat width; CoreOutWidth must be an integer multiple of it; Beats = CoreOutWidth/StreamOutWidth.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  reset, asynchronous, active-low.
csr_reg_set_i  in  RegRWCount x RegDataWidth  configuration words.
csr_reg_set_valid_i  in  1  configuration valid.
csr_reg_set_ready_o  out  1  configuration FIFO not full.
csr_reg_ro_set_o  out  RegROCount x RegDataWidth  read-only status words.
core_cfg_o  out  RegRWCount x RegDataWidth  FIFO head configuration presented to the core.
core_cfg_valid_o  out  1  FIFO not empty.
core_cfg_ready_i  in  1  core accepts the configuration.
core_busy_i  in  1  core is computing.
core_d_i  in  CoreOutWidth  core result word.
core_d_valid_i  in  1  result word valid.
core_d_ready_o  out  1  shell can take a result word.
acc2stream_0_data_o  out  StreamOutWidth  beat to the streamer.
acc2stream_0_valid_o  out  1  beat valid.
acc2stream_0_ready_i  in  1  streamer accepts the beat.

Behaviour:
- Reset, asynchronous on rst_ni low:
  - configuration FIFO emptied; serializer to IDLE; beat_cnt=0; data buffer=0; all counters=0.
  - Outputs during and after reset: csr_reg_set_ready_o=1, core_cfg_valid_o=0, core_d_ready_o=1, acc2stream_0_valid_o=0, acc2stream_0_data_o=0.
  - Reset mid-operation discards queued configurations and pending beats; nothing is replayed.
- Configuration FIFO:
  - Push on csr_reg_set_valid_i && csr_reg_set_ready_o; csr_reg_set_ready_o = !full.
  - Pop on core_cfg_valid_o && core_cfg_ready_i; core_cfg_o = head entry, registered.
  - Latency: a push into an empty FIFO raises core_cfg_valid_o in the next cycle; there is no combinational bypass.
  - Full: ready is low, so no push occurs even if a pop happens in the same cycle. Simultaneous push and pop when neither full nor empty keeps occupancy unchanged.
- Serializer FSM, states IDLE and SEND:
  - IDLE: core_d_ready_o=1, acc2stream_0_valid_o=0. On core_d_valid_i, load core_d_i into the buffer, set beat_cnt=0, go to SEND.
  - SEND: acc2stream_0_valid_o=1; acc2stream_0_data_o = buffer[beat_cnt*StreamOutWidth +: StreamOutWidth], so beat 0 carries the LSBs. Data is held stable while ready is low.
  - On acc2stream_0_ready_i with beat_cnt<Beats-1: increment beat_cnt.
  - On acc2stream_0_ready_i with beat_cnt==Beats-1: the word is complete.
  - core_d_ready_o = IDLE || (SEND && last beat && acc2stream_0_ready_i).
  - Word completion with core_d_valid_i=1: reload the buffer, set beat_cnt=0, stay in SEND. This gives zero-bubble back-to-back throughput.
  - Word completion with core_d_valid_i=0: go to IDLE.
  - Beats=1: one beat per word, same rules apply.
- Status, csr_reg_ro_set_o:
  - [0]: bit0 = busy = core_busy_i || core_cfg_valid_o || (state==SEND), combinational; upper bits 0.
  - [1]: cycle counter. Increments each cycle busy=1 and saturates at all-ones. Cleared to 0 on any configuration push made while busy=0 (start of a new job); in that cycle the counter does not increment.
  - [2]: completed output words. Increments on each last-beat handshake, wraps modulo 2^RegDataWidth, and is cleared by the same clear event as [1].
  - [3..RegROCount-1]: see Optional Feature; any entries beyond [3] read 0.

Optional Feature:
- Macro: SNAX_GEMM_SHELL_STALL_CNT_EN.
- Defined: csr_reg_ro_set_o[3] counts cycles with acc2stream_0_valid_o && !acc2stream_0_ready_i. It saturates at all-ones and is cleared with [1].
- Not defined: [3] is constant 0 and no counter flops are synthesised.

Test Plan:
- Reset state: hold rst_ni=0 with random inputs -> ready_o=1, core_cfg_valid_o=0, acc2stream valid=0, all RO=0. Release reset -> outputs unchanged until stimulus.
- FIFO fill, CfgDepth=2, core_cfg_ready_i=0: push configs A and B -> ready_o=0 after the second push. A third valid is not accepted. Pop -> head changes A->B, ready_o returns to 1 in the next cycle.
- Serialization: core word 0x…03_02_01_00 pattern with each 512-bit slice equal to its index, ready_i=1 -> 4 beats with values 0,1,2,3 on consecutive cycles; ro[2]=1.
- Back-to-back: two core words with core_d_valid_i held high and ready_i=1 -> 8 consecutive valid beats, no bubble; ro[2]=2.
- Backpressure: ready_i low for 5 cycles on beat 2 -> data held stable; ro[3]=5 with the macro, 0 without.
- Counter clear: after a job (ro[1]=N>0) and idle, push a new config -> ro[1]=0 and ro[2]=0 in the next cycle, then ro[1] counts up while busy.
